// File: rtl/sha256_wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter that
// fronts the sha256_top slave.
package sha256_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Default number of wait cycles a strobed access may stall before abort.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/sha256_wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the
// sha256_top slave. Index 0 = network adapter, index 1 = local requester.
interface sha256_wb_arbiter_if;

  // Master side
  logic [1:0][31:0] m_adr_i;
  logic [1:0][31:0] m_dat_i;
  logic [1:0][3:0]  m_sel_i;
  logic [1:0]       m_cyc_i;
  logic [1:0]       m_stb_i;
  logic [1:0]       m_we_i;
  logic [1:0][31:0] m_dat_o;
  logic [1:0]       m_ack_o;
  logic [1:0]       m_err_o;

  // Slave side
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;

  // Arbiter view: consumes master requests and slave responses.
  modport arb (
    input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  // Bus masters view.
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
    input  m_dat_o, m_ack_o, m_err_o
  );

  // sha256_top slave view.
  modport slave (
    input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
    output s_dat_i, s_ack_i, s_err_i
  );

endinterface

// File: rtl/sha256_wb_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, under contention the
// master that was not served last wins.
module sha256_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Pick the winning master index from the current requests.
  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/sha256_wb_arbiter.sv
// Two-master Wishbone arbiter for the sha256_top slave. Grants are taken
// in IDLE with one cycle of latency, the owner keeps the bus while it
// holds cyc, and a stalled strobe is aborted with an error after TIMEOUT
// wait cycles. Bus paths are combinational while BUSY.
module sha256_wb_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  sha256_wb_arbiter_if.arb    bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic [1:0]  req;
  logic        rr_grant;
  logic        rr_valid;
  logic        own_cyc;
  logic        own_stb;
  logic        resp;
  logic        timeout_hit;

  logic [1:0][31:0] m_dat;
  logic [1:0]       m_ack;
  logic [1:0]       m_err;

  assign req = bus.m_cyc_i & bus.m_stb_i;

  sha256_arb_rr u_rr (
    .req   (req),
    .last  (last_q),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // Decode owner handshake and detect the final permitted wait cycle.
  always_comb begin
    own_cyc     = bus.m_cyc_i[owner_q];
    own_stb     = bus.m_stb_i[owner_q];
    resp        = bus.s_ack_i | bus.s_err_i;
    timeout_hit = (state_q == ST_BUSY) && own_cyc && own_stb && !resp &&
                  (cnt_q == TO_LAST);
  end

  // Next-state, ownership and wait-counter logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (rr_valid) begin
          owner_d = rr_grant;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (timeout_hit) begin
          state_d = ST_ABORT;
          cnt_d   = 16'd0;
        end else if (resp || !own_stb) begin
          cnt_d = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ABORT: begin
        cnt_d = 16'd0;
        if (!own_cyc) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // State registers; reset leaves master 0 as first winner under contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus steering: owner mirrored while BUSY, error pulse on timeout, zeros otherwise.
  always_comb begin
    m_dat       = '0;
    m_ack       = 2'b00;
    m_err       = 2'b00;
    bus.s_adr_o = 32'd0;
    bus.s_dat_o = 32'd0;
    bus.s_sel_o = 4'd0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    if (!rst && (state_q == ST_BUSY)) begin
      if (timeout_hit) begin
        m_err[owner_q] = 1'b1;
      end else begin
        bus.s_adr_o    = bus.m_adr_i[owner_q];
        bus.s_dat_o    = bus.m_dat_i[owner_q];
        bus.s_sel_o    = bus.m_sel_i[owner_q];
        bus.s_cyc_o    = own_cyc;
        bus.s_stb_o    = own_stb;
        bus.s_we_o     = bus.m_we_i[owner_q];
        m_dat[owner_q] = bus.s_dat_i;
        m_ack[owner_q] = bus.s_ack_i;
        m_err[owner_q] = bus.s_err_i;
      end
    end else begin
      m_err = 2'b00;
    end
  end

  assign bus.m_dat_o = m_dat;
  assign bus.m_ack_o = m_ack;
  assign bus.m_err_o = m_err;

endmodule

// File: tb/tb_sha256_wb_arbiter.sv
// Directed self-checking bench for sha256_wb_arbiter (TIMEOUT = 8).
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
module tb_sha256_wb_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sha256_wb_arbiter_if bus ();

  sha256_wb_arbiter #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // All DUT outputs folded into one word so "everything is zero" is one check.
  function automatic logic [63:0] out_or();
    return {32'd0, bus.s_adr_o | bus.s_dat_o | bus.m_dat_o[0] | bus.m_dat_o[1]} |
           {56'd0, bus.s_sel_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, 1'b0} |
           {60'd0, bus.m_ack_o, bus.m_err_o};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; bus.m_we_i = 2'b00;
    bus.s_dat_i = 32'd0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;

    // Reset and first idle cycle: everything zero.
    step();
    mid(); check_eq("reset_outputs", out_or(), 64'd0);
    step(); rst = 1'b0;
    mid(); check_eq("idle_after_reset", out_or(), 64'd0);
    step();

    // Simultaneous request: master 0 first, master 1 after release + idle.
    bus.m_adr_i[0] = 32'h0000_0100; bus.m_adr_i[1] = 32'h0000_0200;
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    mid(); check_eq("contend_grant_cycle", {63'd0, bus.s_cyc_o}, 64'd0);
    step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h1111_1111;
    mid(); check_eq("contend_m0_adr", {32'd0, bus.s_adr_o}, 64'h100);
    check_eq("contend_m0_ack", {62'd0, bus.m_ack_o}, 64'd1);
    check_eq("contend_m0_dat", {bus.m_dat_o[1], bus.m_dat_o[0]}, 64'h0000_0000_1111_1111);
    step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    mid();
    step();
    mid(); check_eq("handover_idle", {61'd0, bus.s_cyc_o, bus.m_ack_o}, 64'd0);
    step();
    mid(); check_eq("contend_m1_owns", {31'd0, bus.s_cyc_o, bus.s_adr_o}, 64'h1_0000_0200);
    step();
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    step();
    step();

    // Master 1 write, slave acks after three wait cycles.
    bus.m_adr_i[1] = 32'h0000_0020; bus.m_dat_i[1] = 32'hDEAD_BEEF;
    bus.m_sel_i[1] = 4'hF; bus.m_we_i[1] = 1'b1;
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    mid();
    step();
    for (int w = 0; w < 3; w++) begin
      mid();
      check_eq("wr_wait_bus", {bus.s_adr_o, bus.s_dat_o}, 64'h0000_0020_DEAD_BEEF);
      check_eq("wr_wait_ack", {62'd0, bus.m_ack_o}, 64'd0);
      step();
    end
    bus.s_ack_i = 1'b1;
    mid(); check_eq("wr_ack", {58'd0, bus.s_sel_o, bus.s_we_o, bus.m_ack_o}, {58'd0, 4'hF, 1'b1, 2'b10});
    step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; bus.m_we_i = 2'b00;
    mid(); check_eq("wr_ack_single", {62'd0, bus.m_ack_o}, 64'd0);
    step();
    step();

    // Master 0 holds cyc over 16 writes while master 1 waits.
    bus.m_we_i[0] = 1'b1; bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
    bus.m_adr_i[1] = 32'h0000_0300;
    step();
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.m_adr_i[0] = 32'h1000 + 32'(i);
      bus.s_ack_i = 1'b1;
      mid();
      check_eq("burst_m0", {30'd0, bus.m_ack_o, bus.s_adr_o}, {30'd0, 2'b01, 32'h1000 + 32'(i)});
      step();
    end
    bus.s_ack_i = 1'b0; bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    mid(); check_eq("burst_release", {62'd0, bus.m_ack_o}, 64'd0);
    step();
    mid(); check_eq("burst_idle_gap", {63'd0, bus.s_cyc_o}, 64'd0);
    step();
    mid(); check_eq("burst_m1_owns", {31'd0, bus.s_cyc_o, bus.s_adr_o}, 64'h1_0000_0300);
    step();
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; bus.m_we_i = 2'b00;
    step();
    step();

    // Read with simultaneous ack and err: both pass through.
    bus.m_adr_i[0] = 32'h0000_0040; bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
    step();
    bus.s_dat_i = 32'h6A09_E667; bus.s_ack_i = 1'b1; bus.s_err_i = 1'b1;
    mid();
    check_eq("rd_ack_err", {60'd0, bus.m_ack_o, bus.m_err_o}, {60'd0, 2'b01, 2'b01});
    check_eq("rd_dat", {bus.m_dat_o[1], bus.m_dat_o[0]}, 64'h0000_0000_6A09_E667);
    step();
    bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_dat_i = 32'd0;
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    step();
    step();

    // Timeout: slave never answers, error on the 8th wait cycle.
    bus.m_adr_i[1] = 32'h0000_0030; bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    step();
    for (int w = 1; w <= 8; w++) begin
      mid();
      if (w < 8) begin
        check_eq("to_waiting", {61'd0, bus.s_cyc_o, bus.m_err_o}, {61'd0, 1'b1, 2'b00});
      end else begin
        check_eq("to_err_pulse", {60'd0, bus.s_cyc_o, bus.s_stb_o, bus.m_err_o}, {60'd0, 2'b00, 2'b10});
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      bus.s_ack_i = (k == 1);
      mid();
      check_eq("abort_hold", out_or(), 64'd0);
      step();
    end
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    mid(); check_eq("abort_exit", out_or(), 64'd0);
    step();
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    mid(); check_eq("abort_idle", {63'd0, bus.s_cyc_o}, 64'd0);
    step();

    // Reset while BUSY with an ack pending.
    bus.m_adr_i[0] = 32'h0000_0500; bus.m_adr_i[1] = 32'h0000_0600;
    bus.s_ack_i = 1'b1; rst = 1'b1;
    mid(); check_eq("rst_busy_outputs", out_or(), 64'd0);
    step();
    rst = 1'b0; bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    mid(); check_eq("rst_following_idle", out_or(), 64'd0);
    step();
    mid(); check_eq("rst_m0_wins", {31'd0, bus.s_cyc_o, bus.s_adr_o}, 64'h1_0000_0500);
    step();
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_wb_arbiter.md
SHA256_WB_ARBITER -- requirements
Module: sha256_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles a strobed slave access may wait for ack/err before the arbiter aborts it (range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports m_adr_i/m_dat_i  input  [1:0][31:0]  per-master address/write data; index 0 = network adapter master, 1 = local requester.
REQ-005 SHALL have port m_sel_i  input  [1:0][3:0]  per-master byte selects.
REQ-006 SHALL have ports m_cyc_i/m_stb_i/m_we_i  input  [1:0]  per-master Wishbone cycle/strobe/write.
REQ-007 SHALL have port m_dat_o  output  [1:0][31:0]  per-master read data.
REQ-008 SHALL have ports m_ack_o/m_err_o  output  [1:0]  per-master ack/error.
REQ-009 SHALL have ports s_adr_o/s_dat_o  output  32  address/write data to the sha256_top slave; s_sel_o output 4.
REQ-010 SHALL have ports s_cyc_o/s_stb_o/s_we_o  output  1  slave cycle/strobe/write.
REQ-011 SHALL have ports s_dat_i input 32, s_ack_i/s_err_i input 1  slave responses.

Function
REQ-012 SHALL implement states IDLE, BUSY, ABORT; owner register (1 bit); last-served register (1 bit).
REQ-013 IDLE: request r[i] = m_cyc_i[i] & m_stb_i[i]; one request -> grant it; both -> grant index != last-served; grant registers owner, enters BUSY next cycle (1-cycle grant latency).
REQ-014 BUSY: s_adr/dat/sel/we/stb/cyc_o SHALL equal owner's inputs combinationally; owner's m_ack_o/m_err_o/m_dat_o SHALL equal s_ack_i/s_err_i/s_dat_i.
REQ-015 Non-owner, and every master in IDLE/ABORT except REQ-018, SHALL see m_ack_o=0, m_err_o=0, m_dat_o=0.
REQ-016 Grant SHALL persist across back-to-back strobes while owner holds m_cyc_i; owner dropping m_cyc_i -> last-served=owner, IDLE next cycle (min one idle cycle between owners, no same-cycle handover).
REQ-017 16-bit wait counter: cleared on entering BUSY and on any cycle with s_ack_i|s_err_i or owner stb=0; increments otherwise.
REQ-018 Counter reaching TIMEOUT with no ack/err that cycle -> m_err_o[owner]=1 for exactly one cycle, s_cyc_o=s_stb_o=0 from that cycle, state ABORT.
REQ-019 ABORT: slave outputs 0; remain until owner m_cyc_i=0, then last-served=owner, IDLE.
REQ-020 s_ack_i and s_err_i asserted in the same cycle SHALL both pass to owner unchanged; slave responses arriving in IDLE/ABORT SHALL be dropped.
REQ-021 Slave outputs in IDLE/ABORT SHALL be all-zero.

Reset
REQ-022 rst SHALL force IDLE, owner=0, last-served=1 (master 0 wins first contention), counter=0, all outputs 0 in the reset cycle and the following IDLE cycle.
REQ-023 rst mid-transaction SHALL abandon it with no ack/err issued to any master.

Structure
REQ-024 Shared package sha256_arb_pkg SHALL hold the state enum and TIMEOUT default constant.
REQ-025 Round-robin pick logic SHALL be sub-module sha256_arb_rr (inputs req[1:0], last; output grant index, valid); no other sub-modules.

Verification
REQ-026 After reset, both masters raise cyc/stb same cycle -> master 0 owns at cycle+1; after its release and idle cycle master 1 owns.
REQ-027 Master 1 write adr 0x20 dat 0xDEADBEEF, slave acks after 3 cycles -> s_adr_o=0x20, m_ack_o[1] one cycle, m_ack_o[0]=0 throughout.
REQ-028 Master 0 holds cyc over 16 back-to-back writes while master 1 requests -> master 1 granted only after master 0 drops cyc, plus 1 idle cycle.
REQ-029 TIMEOUT=8, slave never acks -> m_err_o[owner]=1 exactly on 8th wait cycle, s_cyc_o=0 same cycle, ABORT held until cyc drops.
REQ-030 rst asserted during BUSY with ack pending -> next cycle all outputs 0, no m_ack_o/m_err_o pulse, master 0 wins next contention.
REQ-031 Slave read returns 0x6A09E667 with s_err_i=1 same cycle -> owner sees ack=1, err=1, dat=0x6A09E667.
